// File: rtl/lcd_bus_receiver_pkg.sv
// Shared definitions for the LCD bus receiver: FSM states, init nibbles,
// instruction opcode masks and the blank character code.
package lcd_bus_receiver_pkg;

    // Receiver FSM: four power-on init nibbles, then high/low nibble pairs.
    typedef enum logic [2:0] {
        INIT0  = 3'd0,
        INIT1  = 3'd1,
        INIT2  = 3'd2,
        INIT3  = 3'd3,
        NIB_HI = 3'd4,
        NIB_LO = 3'd5
    } lcd_state_e;

    // Nibbles expected during the power-on sequence.
    localparam logic [3:0] INIT_NIB      = 4'h3;
    localparam logic [3:0] INIT_LAST_NIB = 4'h2;

    // Instruction opcodes are identified by their highest set bit.
    localparam logic [7:0] OP_SET_DDRAM = 8'h80;
    localparam logic [7:0] OP_NOP_MASK  = 8'h70;  // CGRAM/function set/shift: ignored
    localparam logic [7:0] OP_DISPLAY   = 8'h08;
    localparam logic [7:0] OP_ENTRY     = 8'h04;
    localparam logic [7:0] OP_HOME      = 8'h02;
    localparam logic [7:0] OP_CLEAR     = 8'h01;

    // Character code written into every cell by a clear.
    localparam logic [7:0] BLANK_CHAR = 8'h20;

endpackage

// File: rtl/lcd_nibble_capture.sv
// Registers the LCD bus once, detects the lcde falling edge and checks that
// the enable pulse was held high for at least MIN_E_CYCLES clocks.
module lcd_nibble_capture #(
    parameter int MIN_E_CYCLES = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcde,
    input  logic       lcdrs,
    input  logic       lcdrw,
    input  logic [3:0] lcddat,
    output logic       o_nib_stb,
    output logic       o_width_err,
    output logic       o_rs,
    output logic       o_rw,
    output logic [3:0] o_nib
);

    localparam int              CNT_W   = $clog2(MIN_E_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_E_CYCLES);

    logic             r_lcde_q;
    logic             r_rs_q;
    logic             r_rw_q;
    logic [3:0]       r_dat_q;
    logic [CNT_W-1:0] r_hi_cnt;
    logic             w_fall;

    // Single register stage for lcde and the bus it qualifies.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lcde_q <= 1'b0;
            r_rs_q   <= 1'b0;
            r_rw_q   <= 1'b0;
            r_dat_q  <= 4'h0;
        end else begin
            r_lcde_q <= lcde;
            r_rs_q   <= lcdrs;
            r_rw_q   <= lcdrw;
            r_dat_q  <= lcddat;
        end
    end

    // Count cycles with lcde high, saturating at the minimum legal width.
    always_ff @(posedge clk) begin
        if (!reset || !lcde) begin
            r_hi_cnt <= '0;
        end else if (r_hi_cnt != CNT_MAX) begin
            r_hi_cnt <= r_hi_cnt + CNT_W'(1);
        end
    end

    // Falling edge: previous sample high, current input low.
    assign w_fall      = r_lcde_q & ~lcde;
    assign o_nib_stb   = w_fall & (r_hi_cnt == CNT_MAX);
    assign o_width_err = w_fall & (r_hi_cnt != CNT_MAX);
    assign o_rs        = r_rs_q;
    assign o_rw        = r_rw_q;
    assign o_nib       = r_dat_q;

endmodule

// File: rtl/lcd_bus_receiver.sv
// HD44780-style 4-bit LCD bus receiver: checks the init sequence, pairs
// nibbles into bytes and tracks display state and the DDRAM address.
// Optional feature macro: LCD_RX_SHADOW_EN adds a readable shadow DDRAM.
module lcd_bus_receiver
    import lcd_bus_receiver_pkg::*;
#(
    parameter int ADDR_W       = 7,
    parameter int MIN_E_CYCLES = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lcde,
    input  logic              lcdrs,
    input  logic              lcdrw,
    input  logic [3:0]        lcddat,
    output logic              init_done,
    output logic              cmd_valid,
    output logic              cmd_rs,
    output logic [7:0]        cmd_byte,
    output logic              char_we,
    output logic [ADDR_W-1:0] char_addr,
    output logic [7:0]        char_data,
    output logic [ADDR_W-1:0] ddram_addr,
    output logic              display_on,
    output logic              cursor_on,
    output logic              blink_on,
    output logic              clear_pulse,
    output logic              proto_err,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    lcd_state_e r_state;
    lcd_state_e w_state_next;
    logic       r_hi_rs;
    logic [3:0] r_hi_nib;
    logic       r_inc_mode;

    logic       w_nib_stb;
    logic       w_width_err;
    logic       w_rs;
    logic       w_rw;
    logic [3:0] w_nib;
    logic       w_err;
    logic       w_cmd_fire;
    logic       w_init_fire;
    logic       w_hi_load;
    logic       w_init_ok;
    logic [7:0] w_byte;
    logic       w_char_fire;
    logic       w_clear_fire;

    lcd_nibble_capture #(
        .MIN_E_CYCLES(MIN_E_CYCLES)
    ) u_capture (
        .clk        (clk),
        .reset      (reset),
        .lcde       (lcde),
        .lcdrs      (lcdrs),
        .lcdrw      (lcdrw),
        .lcddat     (lcddat),
        .o_nib_stb  (w_nib_stb),
        .o_width_err(w_width_err),
        .o_rs       (w_rs),
        .o_rw       (w_rw),
        .o_nib      (w_nib)
    );

    assign w_init_ok    = (w_nib == INIT_NIB) && !w_rs;
    assign w_byte       = {r_hi_nib, w_nib};
    assign w_char_fire  = w_cmd_fire && w_rs;
    assign w_clear_fire = w_cmd_fire && !w_rs && (w_byte == OP_CLEAR);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= INIT0;
        else        r_state <= w_state_next;
    end

    // Next-state and event decode for each accepted nibble.
    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_err        = w_width_err;
        w_cmd_fire   = 1'b0;
        w_init_fire  = 1'b0;
        w_hi_load    = 1'b0;
        if (w_nib_stb) begin
            if (w_rw) begin
                w_err = 1'b1;
            end else begin
                case (r_state)
                    INIT0: begin
                        w_state_next = w_init_ok ? INIT1 : INIT0;
                        w_err        = !w_init_ok;
                    end
                    INIT1: begin
                        w_state_next = w_init_ok ? INIT2 : INIT0;
                        w_err        = !w_init_ok;
                    end
                    INIT2: begin
                        w_state_next = w_init_ok ? INIT3 : INIT0;
                        w_err        = !w_init_ok;
                    end
                    INIT3: begin
                        if ((w_nib == INIT_LAST_NIB) && !w_rs) begin
                            w_state_next = NIB_HI;
                            w_init_fire  = 1'b1;
                        end else begin
                            w_state_next = INIT0;
                            w_err        = 1'b1;
                        end
                    end
                    NIB_HI: begin
                        w_hi_load    = 1'b1;
                        w_state_next = NIB_LO;
                    end
                    NIB_LO: begin
                        w_cmd_fire   = (w_rs == r_hi_rs);
                        w_err        = (w_rs != r_hi_rs);
                        w_state_next = NIB_HI;
                    end
                    default: w_state_next = INIT0;
                endcase
            end
        end
    end

    // Byte assembly, instruction decode, character writes and pulse outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi_nib    <= 4'h0;
            r_hi_rs     <= 1'b0;
            r_inc_mode  <= 1'b1;
            init_done   <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_rs      <= 1'b0;
            cmd_byte    <= 8'h00;
            char_we     <= 1'b0;
            char_addr   <= '0;
            char_data   <= 8'h00;
            ddram_addr  <= '0;
            display_on  <= 1'b0;
            cursor_on   <= 1'b0;
            blink_on    <= 1'b0;
            clear_pulse <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            cmd_valid   <= w_cmd_fire;
            proto_err   <= w_err;
            char_we     <= 1'b0;
            clear_pulse <= 1'b0;
            if (w_init_fire) init_done <= 1'b1;
            if (w_hi_load) begin
                r_hi_nib <= w_nib;
                r_hi_rs  <= w_rs;
            end
            if (w_cmd_fire) begin
                cmd_byte <= w_byte;
                cmd_rs   <= w_rs;
                if (w_rs) begin
                    char_we    <= 1'b1;
                    char_addr  <= ddram_addr;
                    char_data  <= w_byte;
                    ddram_addr <= r_inc_mode ? ddram_addr + ADDR_W'(1)
                                             : ddram_addr - ADDR_W'(1);
                end else if ((w_byte & OP_SET_DDRAM) != 8'h00) begin
                    ddram_addr <= w_byte[ADDR_W-1:0];
                end else if ((w_byte & OP_NOP_MASK) != 8'h00) begin
                    // CGRAM address, function set and shift: no tracked state.
                end else if ((w_byte & OP_DISPLAY) != 8'h00) begin
                    display_on <= w_byte[2];
                    cursor_on  <= w_byte[1];
                    blink_on   <= w_byte[0];
                end else if ((w_byte & OP_ENTRY) != 8'h00) begin
                    r_inc_mode <= w_byte[1];
                end else if ((w_byte & OP_HOME) != 8'h00) begin
                    ddram_addr <= '0;
                end else if ((w_byte & OP_CLEAR) != 8'h00) begin
                    ddram_addr  <= '0;
                    clear_pulse <= 1'b1;
                end
            end
        end
    end

`ifdef LCD_RX_SHADOW_EN
    localparam int RAM_DEPTH = 1 << ADDR_W;

    logic [7:0]        r_mem [RAM_DEPTH];
    logic [7:0]        r_rd_data;
    logic              r_fill_busy;
    logic [ADDR_W-1:0] r_fill_idx;

    // Blank-fill sequencer: one cell per cycle after a clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fill_busy <= 1'b0;
            r_fill_idx  <= '0;
        end else if (w_clear_fire) begin
            r_fill_busy <= 1'b1;
            r_fill_idx  <= '0;
        end else if (r_fill_busy) begin
            r_fill_idx <= r_fill_idx + ADDR_W'(1);
            if (r_fill_idx == '1) r_fill_busy <= 1'b0;
        end
    end

    // Shadow DDRAM writes and registered read port.
    // NOTE: the RAM array has no reset so it maps onto plain memory and keeps
    // its contents across a receiver reset.
    always_ff @(posedge clk) begin
        if (r_fill_busy) r_mem[r_fill_idx] <= BLANK_CHAR;
        if (w_char_fire) r_mem[ddram_addr] <= w_byte;
        r_rd_data <= r_mem[rd_addr];
    end

    assign rd_data = r_rd_data;
`else
    logic w_unused_rd;

    assign w_unused_rd = (^rd_addr) ^ w_char_fire ^ w_clear_fire;
    assign rd_data     = 8'h00;
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed testbench for lcd_bus_receiver.
module tb_lcd_bus_receiver;
    import lcd_bus_receiver_pkg::*;

    localparam int ADDR_W = 7;
    localparam int MIN_E  = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              lcde;
    logic              lcdrs;
    logic              lcdrw;
    logic [3:0]        lcddat;
    logic              init_done;
    logic              cmd_valid;
    logic              cmd_rs;
    logic [7:0]        cmd_byte;
    logic              char_we;
    logic [ADDR_W-1:0] char_addr;
    logic [7:0]        char_data;
    logic [ADDR_W-1:0] ddram_addr;
    logic              display_on;
    logic              cursor_on;
    logic              blink_on;
    logic              clear_pulse;
    logic              proto_err;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    int checks   = 0;
    int failures = 0;

    int         n_cmd = 0;
    int         n_err = 0;
    int         n_we  = 0;
    int         n_clr = 0;
    logic [7:0] last_byte  = 8'h00;
    logic       last_rs    = 1'b0;
    logic [7:0] last_caddr = 8'h00;
    logic [7:0] last_cdata = 8'h00;

    lcd_bus_receiver #(
        .ADDR_W      (ADDR_W),
        .MIN_E_CYCLES(MIN_E)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lcde       (lcde),
        .lcdrs      (lcdrs),
        .lcdrw      (lcdrw),
        .lcddat     (lcddat),
        .init_done  (init_done),
        .cmd_valid  (cmd_valid),
        .cmd_rs     (cmd_rs),
        .cmd_byte   (cmd_byte),
        .char_we    (char_we),
        .char_addr  (char_addr),
        .char_data  (char_data),
        .ddram_addr (ddram_addr),
        .display_on (display_on),
        .cursor_on  (cursor_on),
        .blink_on   (blink_on),
        .clear_pulse(clear_pulse),
        .proto_err  (proto_err),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (cmd_valid) begin
            n_cmd++;
            last_byte = cmd_byte;
            last_rs   = cmd_rs;
        end
        if (proto_err) n_err++;
        if (clear_pulse) n_clr++;
        if (char_we) begin
            n_we++;
            last_caddr = 8'(char_addr);
            last_cdata = char_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one nibble with lcde high for 'width' clocks; returns on the
    // falling clock edge right after the capturing rising edge.
    task automatic send_nib(input logic rs, input logic rw, input logic [3:0] nib, input int width);
        repeat (2) @(negedge clk);
        lcdrs  = rs;
        lcdrw  = rw;
        lcddat = nib;
        lcde   = 1'b1;
        repeat (width) @(negedge clk);
        lcde = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b);
        send_nib(rs, 1'b0, b[7:4], MIN_E);
        send_nib(rs, 1'b0, b[3:0], MIN_E);
        repeat (3) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

`ifdef LCD_RX_SHADOW_EN
    task automatic read_shadow(input logic [ADDR_W-1:0] a, input string tag, input logic [7:0] exp);
        rd_addr = a;
        repeat (2) @(negedge clk);
        check(tag, 32'(rd_data), 32'(exp));
    endtask
`endif

    // Hard time limit so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        int cmd0;
        int err0;
        int we0;

        reset   = 1'b0;
        lcde    = 1'b0;
        lcdrs   = 1'b0;
        lcdrw   = 1'b0;
        lcddat  = 4'h0;
        rd_addr = '0;
        idle(4);

        // Reset values
        check("rst_state",      32'(dut.r_state), 32'(INIT0));
        check("rst_init_done",  32'(init_done),   32'd0);
        check("rst_ddram",      32'(ddram_addr),  32'd0);
        check("rst_inc_mode",   32'(dut.r_inc_mode), 32'd1);
        check("rst_flags",      32'({display_on, cursor_on, blink_on}), 32'd0);
        check("rst_pulses",     32'({cmd_valid, char_we, clear_pulse, proto_err}), 32'd0);
        check("rst_cmd",        32'({cmd_rs, cmd_byte}), 32'd0);
`ifndef LCD_RX_SHADOW_EN
        check("rst_rd_data",    32'(rd_data), 32'd0);
`endif
        reset = 1'b1;
        idle(2);

        // Bad init: 3,3,5
        send_nib(1'b0, 1'b0, 4'h3, MIN_E);
        send_nib(1'b0, 1'b0, 4'h3, MIN_E);
        send_nib(1'b0, 1'b0, 4'h5, MIN_E);
        check("bad_init_err_pulse", 32'(proto_err), 32'd1);
        idle(3);
        check("bad_init_err_cnt", 32'(n_err), 32'd1);
        check("bad_init_state",   32'(dut.r_state), 32'(INIT0));
        check("bad_init_done",    32'(init_done), 32'd0);

        // Good init: 3,3,3,2
        send_nib(1'b0, 1'b0, 4'h3, MIN_E);
        send_nib(1'b0, 1'b0, 4'h3, MIN_E);
        send_nib(1'b0, 1'b0, 4'h3, MIN_E);
        send_nib(1'b0, 1'b0, 4'h2, MIN_E);
        idle(3);
        check("init_done",  32'(init_done), 32'd1);
        check("init_state", 32'(dut.r_state), 32'(NIB_HI));
        check("init_no_err", 32'(n_err), 32'd1);

        // Set DDRAM address 0x40, then write 'A'
        send_byte(1'b0, 8'hC0);
        check("setaddr_cmd_cnt", 32'(n_cmd), 32'd1);
        check("setaddr_byte",    32'({last_rs, last_byte}), 32'h0C0);
        check("setaddr_ddram",   32'(ddram_addr), 32'h40);
        send_nib(1'b1, 1'b0, 4'h4, MIN_E);
        send_nib(1'b1, 1'b0, 4'h1, MIN_E);
        check("data_cmd_latency", 32'({cmd_valid, char_we}), 32'h3);
        idle(1);
        check("data_cmd_one_cycle", 32'({cmd_valid, char_we}), 32'h0);
        idle(2);
        check("data_we_cnt",   32'(n_we), 32'd1);
        check("data_char_addr", 32'(last_caddr), 32'h40);
        check("data_char_data", 32'(last_cdata), 32'h41);
        check("data_cmd",      32'({last_rs, last_byte}), 32'h141);
        check("data_ddram",    32'(ddram_addr), 32'h41);

        // Increment wrap 0x7F -> 0x00
        send_byte(1'b0, 8'hFF);
        check("addr7f_ddram", 32'(ddram_addr), 32'h7F);
        send_byte(1'b1, 8'h55);
        check("wrap_inc_char_addr", 32'(last_caddr), 32'h7F);
        check("wrap_inc_ddram",     32'(ddram_addr), 32'h00);
        // Entry mode decrement, wrap 0x00 -> 0x7F
        send_byte(1'b0, 8'h04);
        check("entry_inc_mode", 32'(dut.r_inc_mode), 32'd0);
        send_byte(1'b1, 8'h66);
        check("wrap_dec_char_addr", 32'(last_caddr), 32'h00);
        check("wrap_dec_char_data", 32'(last_cdata), 32'h66);
        check("wrap_dec_ddram",     32'(ddram_addr), 32'h7F);

        // Display control 0x0E
        send_byte(1'b0, 8'h0E);
        check("disp_flags", 32'({display_on, cursor_on, blink_on}), 32'b110);

`ifdef LCD_RX_SHADOW_EN
        read_shadow(7'h40, "shadow_before_clear", 8'h41);
`endif
        // Clear display
        send_byte(1'b0, 8'h01);
        check("clear_pulse_cnt", 32'(n_clr), 32'd1);
        check("clear_ddram",     32'(ddram_addr), 32'h00);
        idle(140);
`ifdef LCD_RX_SHADOW_EN
        read_shadow(7'h00, "shadow_blank_00", BLANK_CHAR);
        read_shadow(7'h40, "shadow_blank_40", BLANK_CHAR);
        read_shadow(7'h7F, "shadow_blank_7f", BLANK_CHAR);
`else
        check("no_shadow_rd_data", 32'(rd_data), 32'd0);
`endif

        // Short lcde pulse (MIN_E-1 cycles)
        cmd0 = n_cmd;
        err0 = n_err;
        send_nib(1'b0, 1'b0, 4'h8, MIN_E - 1);
        idle(3);
        check("short_e_err",   32'(n_err - err0), 32'd1);
        check("short_e_state", 32'(dut.r_state), 32'(NIB_HI));

        // lcdrw=1 in NIB_HI and in NIB_LO: nibble ignored, state kept
        send_nib(1'b0, 1'b1, 4'h8, MIN_E);
        idle(3);
        check("rw_hi_err",   32'(n_err - err0), 32'd2);
        check("rw_hi_state", 32'(dut.r_state), 32'(NIB_HI));
        send_nib(1'b0, 1'b0, 4'h0, MIN_E);
        send_nib(1'b0, 1'b1, 4'hF, MIN_E);
        idle(3);
        check("rw_lo_state", 32'(dut.r_state), 32'(NIB_LO));
        check("rw_no_cmd",   32'(n_cmd - cmd0), 32'd0);
        send_nib(1'b0, 1'b0, 4'h8, MIN_E);
        idle(3);
        check("rw_resume_byte",  32'(last_byte), 32'h08);
        check("rw_resume_flags", 32'({display_on, cursor_on, blink_on}), 32'b000);
        check("rw_err_total",    32'(n_err - err0), 32'd3);

        // RS mismatch between halves
        cmd0 = n_cmd;
        send_nib(1'b0, 1'b0, 4'h0, MIN_E);
        send_nib(1'b1, 1'b0, 4'hC, MIN_E);
        idle(3);
        check("rs_mismatch_err",   32'(n_err - err0), 32'd4);
        check("rs_mismatch_nocmd", 32'(n_cmd - cmd0), 32'd0);
        check("rs_mismatch_state", 32'(dut.r_state), 32'(NIB_HI));

        // Reset between the two nibbles of a data byte
        we0 = n_we;
        send_nib(1'b1, 1'b0, 4'h4, MIN_E);
        reset = 1'b0;
        idle(2);
        check("midrst_state", 32'(dut.r_state), 32'(INIT0));
        check("midrst_init",  32'(init_done), 32'd0);
        check("midrst_inc",   32'(dut.r_inc_mode), 32'd1);
        reset = 1'b1;
        send_nib(1'b1, 1'b0, 4'h1, MIN_E);
        idle(3);
        check("midrst_no_cmd", 32'(n_cmd - cmd0), 32'd0);
        check("midrst_no_we",  32'(n_we - we0), 32'd0);
        check("midrst_state2", 32'(dut.r_state), 32'(INIT0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
